multiport_lookahead_ram: RTL and testbench

Parametrised successor to the single-read-port state RAM used by the DFA/adapter blocks. It provides one write port with byte enables and NUM_RD independent read ports. Each read port has 1-cycle registered latency and write-first lookahead bypass. A clear sweep runs after reset and on demand, and is signalled by wr_waitrequest. It holds per-channel state for multi-channel adapters: one address per channel, one read port per pipeline stage.

---
 rtl/multiport_lookahead_ram.sv | 114 +++++++++++
 tb/tb_multiport_lookahead_ram.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_lookahead_ram.sv
// Multi-read-port state RAM with byte-enabled writes and a write-first lookahead bypass.
// A clear sweep runs after reset and on demand; wr_waitrequest is high while it runs.
module multiport_lookahead_ram #(
   parameter int                DATA_W         = 16,
   parameter int                DEPTH          = 8,
   parameter int                ADDR_W         = 3,
   parameter int                NUM_RD         = 2,
   parameter int                CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          wr_address,
   input  logic [DATA_W-1:0]          wr_writedata,
   input  logic [DATA_W/8-1:0]        wr_byteenable,
   input  logic                       wr_write,
   output logic                       wr_waitrequest,
   input  logic                       clear,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_address,
   output logic [NUM_RD*DATA_W-1:0]   rd_readdata
);

   localparam int                NB        = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_waitreq;
   logic              r_sweep_en;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_wdata;

   logic              w_wr_commit;
   logic              w_sweep_wr;
   logic [DATA_W-1:0] w_wr_mask;

   assign wr_waitrequest = r_waitreq;
   assign w_sweep_wr     = r_waitreq & r_sweep_en;

   always_comb begin
      w_wr_commit = wr_write & ~r_waitreq & ({1'b0, wr_address} < DEPTH_LIM);
      w_wr_mask   = '0;
      for (int b = 0; b < NB; b++) begin
         w_wr_mask[b*8 +: 8] = {8{wr_byteenable[b]}};
      end
   end

   // r_sweep_en distinguishes a real sweep from the single-edge
   // wait that follows reset when CLEAR_ON_RESET is 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitreq  <= 1'b1;
         r_cnt      <= LAST_ADDR;
         r_sweep_en <= (CLEAR_ON_RESET != 0);
      end else if (r_waitreq) begin
         if (!r_sweep_en || r_cnt == '0) begin
            r_waitreq <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end else if (clear) begin
         r_waitreq  <= 1'b1;
         r_cnt      <= LAST_ADDR;
         r_sweep_en <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_sweep_wr) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
         end else if (w_wr_commit) begin
            for (int b = 0; b < NB; b++) begin
               if (wr_byteenable[b]) begin
                  r_mem[wr_address][b*8 +: 8] <= wr_writedata[b*8 +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdata <= '0;
      end else begin
         r_wdata <= wr_writedata;
      end
   end

   // Each port keeps the pre-write word plus a per-bit bypass mask; the
   // write-first merge happens after the registers.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_valid;
      logic [DATA_W-1:0] r_old;
      logic [DATA_W-1:0] r_mask;

      assign w_addr  = rd_address[p*ADDR_W +: ADDR_W];
      assign w_valid = ~r_waitreq & ({1'b0, w_addr} < DEPTH_LIM);

      always_ff @(posedge clk) begin
         if (reset || !w_valid) begin
            r_old  <= '0;
            r_mask <= '0;
         end else begin
            r_old  <= r_mem[w_addr];
            r_mask <= (w_wr_commit && wr_address == w_addr) ? w_wr_mask : '0;
         end
      end

      assign rd_readdata[p*DATA_W +: DATA_W] = (r_old & ~r_mask) | (r_wdata & r_mask);
   end

endmodule

// File: tb/tb_multiport_lookahead_ram.sv
// Directed bench for multiport_lookahead_ram: sweep timing, bypass, independent
// ports, runtime clear, reset mid-sweep, plus a 4-port randomised scoreboard run.
module tb_multiport_lookahead_ram;

   localparam logic [15:0] CV = 16'hA5A5;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // DUT A: DEPTH=8, ADDR_W=4, 2 ports, sweep on reset
   logic        a_reset = 1'b1;
   logic [3:0]  a_wr_addr = '0;
   logic [15:0] a_wr_data = '0;
   logic [1:0]  a_wr_be = '0;
   logic        a_wr = 1'b0;
   logic        a_wait;
   logic        a_clear = 1'b0;
   logic [7:0]  a_rd_addr = '0;
   logic [31:0] a_rd_data;

   multiport_lookahead_ram #(
      .DATA_W(16), .DEPTH(8), .ADDR_W(4), .NUM_RD(2),
      .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
   ) u_dut_a (
      .clk(clk), .reset(a_reset),
      .wr_address(a_wr_addr), .wr_writedata(a_wr_data), .wr_byteenable(a_wr_be),
      .wr_write(a_wr), .wr_waitrequest(a_wait), .clear(a_clear),
      .rd_address(a_rd_addr), .rd_readdata(a_rd_data)
   );

   // DUT B: DEPTH=5, ADDR_W=3, 4 ports, no sweep on reset
   logic        b_reset = 1'b1;
   logic [2:0]  b_wr_addr = '0;
   logic [15:0] b_wr_data = '0;
   logic [1:0]  b_wr_be = '0;
   logic        b_wr = 1'b0;
   logic        b_wait;
   logic        b_clear = 1'b0;
   logic [11:0] b_rd_addr = '0;
   logic [63:0] b_rd_data;

   multiport_lookahead_ram #(
      .DATA_W(16), .DEPTH(5), .ADDR_W(3), .NUM_RD(4),
      .CLEAR_ON_RESET(0), .CLEAR_VALUE(16'h0000)
   ) u_dut_b (
      .clk(clk), .reset(b_reset),
      .wr_address(b_wr_addr), .wr_writedata(b_wr_data), .wr_byteenable(b_wr_be),
      .wr_write(b_wr), .wr_waitrequest(b_wait), .clear(b_clear),
      .rd_address(b_rd_addr), .rd_readdata(b_rd_data)
   );

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
      a_wr_addr = addr; a_wr_data = data; a_wr_be = be; a_wr = 1'b1;
      tick();
      a_wr = 1'b0;
   endtask

   task automatic test_reset();
      a_reset = 1'b1;
      a_rd_addr = {4'd1, 4'd0};
      tick(); tick();
      n_tests++;
      if (a_wait !== 1'b1) begin
         n_fail++; $display("FAIL reset_wait: got %b want 1", a_wait);
      end
      n_tests++;
      if (a_rd_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_rd: got %h want 0", a_rd_data);
      end
   endtask

   task automatic test_sweep_after_reset();
      int n = 0;
      a_reset = 1'b0;
      a_rd_addr = {4'd7, 4'd0};
      while (a_wait === 1'b1 && n < 50) begin
         tick();
         n++;
         n_tests++;
         if (a_rd_data !== 32'h0) begin
            n_fail++; $display("FAIL sweep_rd_zero edge %0d: got %h want 0", n, a_rd_data);
         end
      end
      n_tests++;
      if (n !== 8) begin
         n_fail++; $display("FAIL sweep_len: got %0d edges want 8", n);
      end
      for (int i = 0; i < 8; i++) begin
         a_rd_addr = {4'(i), 4'(i)};
         tick();
         n_tests++;
         if (a_rd_data !== {CV, CV}) begin
            n_fail++; $display("FAIL sweep_value addr %0d: got %h want %h", i, a_rd_data, {CV, CV});
         end
      end
   endtask

   task automatic test_bypass();
      a_write(4'd3, 16'h1234, 2'b11);
      a_rd_addr = {4'd3, 4'd3};
      a_write(4'd3, 16'hABCD, 2'b01);
      n_tests++;
      if (a_rd_data !== 32'h12CD_12CD) begin
         n_fail++; $display("FAIL bypass_merge: got %h want 12cd12cd", a_rd_data);
      end
      tick();
      n_tests++;
      if (a_rd_data !== 32'h12CD_12CD) begin
         n_fail++; $display("FAIL bypass_after: got %h want 12cd12cd", a_rd_data);
      end
      // a zero-byte-enable write must not change the word or bypass anything
      a_write(4'd3, 16'hFFFF, 2'b00);
      n_tests++;
      if (a_rd_data !== 32'h12CD_12CD) begin
         n_fail++; $display("FAIL be_zero: got %h want 12cd12cd", a_rd_data);
      end
   endtask

   task automatic test_independent_ports();
      logic [15:0] e0, e1;
      for (int i = 0; i < 8; i++) a_write(4'(i), 16'h1000 + 16'(i), 2'b11);
      for (int i = 0; i < 8; i++) begin
         a_rd_addr = {4'(7 - i), 4'(i)};
         tick();
         e0 = 16'h1000 + 16'(i);
         e1 = 16'h1000 + 16'(7 - i);
         n_tests++;
         if (a_rd_data !== {e1, e0}) begin
            n_fail++; $display("FAIL ports step %0d: got %h want %h", i, a_rd_data, {e1, e0});
         end
      end
      a_rd_addr = {4'd2, 4'd9};
      tick();
      n_tests++;
      if (a_rd_data !== 32'h1002_0000) begin
         n_fail++; $display("FAIL out_of_range: got %h want 10020000", a_rd_data);
      end
   endtask

   task automatic test_runtime_clear();
      int n = 0;
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      n_tests++;
      if (a_wait !== 1'b1) begin
         n_fail++; $display("FAIL clear_start: got %b want 1", a_wait);
      end
      while (a_wait === 1'b1 && n < 50) begin
         a_wr = (n == 0);
         a_wr_addr = 4'd2; a_wr_data = 16'h5555; a_wr_be = 2'b11;
         a_clear = (n == 3);
         tick();
         n++;
      end
      a_wr = 1'b0; a_clear = 1'b0;
      n_tests++;
      if (n !== 8) begin
         n_fail++; $display("FAIL clear_len: got %0d edges want 8", n);
      end
      a_rd_addr = {4'd2, 4'd2};
      tick();
      n_tests++;
      if (a_rd_data !== {CV, CV}) begin
         n_fail++; $display("FAIL clear_ignored_write: got %h want %h", a_rd_data, {CV, CV});
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n = 0;
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      tick(); tick(); tick();
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      n_tests++;
      if (a_wait !== 1'b1 || a_rd_data !== 32'h0) begin
         n_fail++; $display("FAIL mid_sweep_reset: got wait=%b rd=%h want wait=1 rd=0", a_wait, a_rd_data);
      end
      while (a_wait === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n_tests++;
      if (n !== 8) begin
         n_fail++; $display("FAIL restart_len: got %0d edges want 8", n);
      end
      // reset while a valid read is in flight
      a_write(4'd1, 16'h7777, 2'b11);
      a_rd_addr = {4'd1, 4'd1};
      tick();
      n_tests++;
      if (a_rd_data !== 32'h7777_7777) begin
         n_fail++; $display("FAIL traffic_read: got %h want 77777777", a_rd_data);
      end
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      n_tests++;
      if (a_rd_data !== 32'h0) begin
         n_fail++; $display("FAIL traffic_reset_rd: got %h want 0", a_rd_data);
      end
      n = 0;
      while (a_wait === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      tick();
      n_tests++;
      if (n !== 8 || a_rd_data !== {CV, CV}) begin
         n_fail++; $display("FAIL traffic_resweep: got %0d edges rd=%h want 8 %h", n, a_rd_data, {CV, CV});
      end
   endtask

   task automatic test_random_regression();
      logic [15:0] model [5];
      logic [15:0] exp_d [4];
      logic [2:0]  ra;
      logic        commit;
      int          errs = 0;
      b_reset = 1'b1;
      tick(); tick();
      b_reset = 1'b0;
      tick();
      n_tests++;
      if (b_wait !== 1'b0) begin
         n_fail++; $display("FAIL nosweep_wait: got %b want 0", b_wait);
      end
      for (int i = 0; i < 5; i++) begin
         model[i] = 16'($urandom);
         b_wr_addr = 3'(i); b_wr_data = model[i]; b_wr_be = 2'b11; b_wr = 1'b1;
         tick();
      end
      for (int c = 0; c < 2000; c++) begin
         b_wr      = 1'($urandom_range(0, 1));
         b_wr_addr = 3'($urandom_range(0, 7));
         b_wr_data = 16'($urandom);
         b_wr_be   = 2'($urandom_range(0, 3));
         for (int p = 0; p < 4; p++) b_rd_addr[p*3 +: 3] = 3'($urandom_range(0, 7));
         commit = b_wr && (b_wr_addr < 3'd5);
         if (commit) begin
            if (b_wr_be[0]) model[b_wr_addr][7:0]  = b_wr_data[7:0];
            if (b_wr_be[1]) model[b_wr_addr][15:8] = b_wr_data[15:8];
         end
         for (int p = 0; p < 4; p++) begin
            ra = b_rd_addr[p*3 +: 3];
            exp_d[p] = (ra < 3'd5) ? model[ra] : 16'h0;
         end
         tick();
         for (int p = 0; p < 4; p++) begin
            n_tests++;
            if (b_rd_data[p*16 +: 16] !== exp_d[p]) begin
               n_fail++;
               if (errs < 10) $display("FAIL rand cycle %0d port %0d: got %h want %h",
                                        c, p, b_rd_data[p*16 +: 16], exp_d[p]);
               errs++;
            end
         end
      end
      b_wr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sweep_after_reset();
      test_bypass();
      test_independent_ports();
      test_runtime_clear();
      test_reset_mid_sweep();
      test_random_regression();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
